// File: rtl/mycpu_pkg.sv
// Shared definitions for the mycpu multi-cycle datapath.
// State codes are fixed so trace debug can decode them.
package mycpu_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IF_REQ   = 3'd0;
    localparam logic [STATE_W-1:0] S_IF_WAIT  = 3'd1;
    localparam logic [STATE_W-1:0] S_ID       = 3'd2;
    localparam logic [STATE_W-1:0] S_EXE      = 3'd3;
    localparam logic [STATE_W-1:0] S_MEM_REQ  = 3'd4;
    localparam logic [STATE_W-1:0] S_MEM_WAIT = 3'd5;
    localparam logic [STATE_W-1:0] S_WB       = 3'd6;

endpackage

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle sequencer: IF -> ID -> EXE -> (MEM) -> WB.
// Emits one-cycle latch enables and SRAM requests; counts retirements.
module mc_ctrl_fsm
    import mycpu_pkg::*;
#(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 inst_req,
    input  logic                 inst_rvalid,
    output logic                 data_req,
    output logic                 data_wr,
    input  logic                 data_rvalid,
    input  logic                 dec_load,
    input  logic                 dec_store,
    input  logic                 dec_gr_we,
    input  logic                 dec_br_taken,
    output logic                 ir_we,
    output logic                 opnd_we,
    output logic                 alu_res_we,
    output logic                 mdr_we,
    output logic                 pc_we,
    output logic                 pc_sel_br,
    output logic                 rf_we,
    output logic                 retire,
    output logic [STATE_W-1:0]   state,
    output logic [INSTRET_W-1:0] instret
);

    logic [STATE_W-1:0] state_n;
    logic ld_q;
    logic st_q;
    logic gwe_q;
    logic br_q;

    // Next-state and strobe decode; strobes are held low during reset.
    always_comb begin
        state_n    = state;
        inst_req   = 1'b0;
        ir_we      = 1'b0;
        opnd_we    = 1'b0;
        alu_res_we = 1'b0;
        data_req   = 1'b0;
        data_wr    = 1'b0;
        mdr_we     = 1'b0;
        pc_we      = 1'b0;
        pc_sel_br  = 1'b0;
        rf_we      = 1'b0;
        retire     = 1'b0;
        case (state)
            S_IF_REQ: begin
                inst_req = 1'b1;
                state_n  = S_IF_WAIT;
            end
            S_IF_WAIT: begin
                if (inst_rvalid) begin
                    ir_we   = 1'b1;
                    state_n = S_ID;
                end
            end
            S_ID: begin
                opnd_we = 1'b1;
                state_n = S_EXE;
            end
            S_EXE: begin
                alu_res_we = 1'b1;
                state_n    = (ld_q | st_q) ? S_MEM_REQ : S_WB;
            end
            S_MEM_REQ: begin
                data_req = 1'b1;
                data_wr  = st_q;
                state_n  = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                if (data_rvalid) begin
                    mdr_we  = ld_q;
                    state_n = S_WB;
                end
            end
            S_WB: begin
                rf_we     = gwe_q & ~st_q;
                pc_we     = 1'b1;
                pc_sel_br = br_q;
                retire    = 1'b1;
                state_n   = S_IF_REQ;
            end
            default: state_n = S_IF_REQ;
        endcase
        if (reset) begin
            inst_req   = 1'b0;
            ir_we      = 1'b0;
            opnd_we    = 1'b0;
            alu_res_we = 1'b0;
            data_req   = 1'b0;
            data_wr    = 1'b0;
            mdr_we     = 1'b0;
            pc_we      = 1'b0;
            pc_sel_br  = 1'b0;
            rf_we      = 1'b0;
            retire     = 1'b0;
        end
    end

    // State, decoded-instruction flags and retirement counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IF_REQ;
            ld_q    <= 1'b0;
            st_q    <= 1'b0;
            gwe_q   <= 1'b0;
            br_q    <= 1'b0;
            instret <= '0;
        end else begin
            state <= state_n;
            if (state == S_ID) begin
                ld_q  <= dec_load;
                st_q  <= dec_store;
                gwe_q <= dec_gr_we;
            end
            if (state == S_EXE) begin
                br_q <= dec_br_taken;
            end
            if (retire) begin
                instret <= instret + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_mc_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_rvalid;
    logic        data_req, data_wr, data_rvalid;
    logic        dec_load, dec_store, dec_gr_we, dec_br_taken;
    logic        ir_we, opnd_we, alu_res_we, mdr_we;
    logic        pc_we, pc_sel_br, rf_we, retire;
    logic [2:0]  state;
    logic [31:0] instret;

    int checks = 0;
    int failures = 0;

    // strobe order: inst_req ir_we opnd_we alu_res_we data_req data_wr
    //               mdr_we pc_we pc_sel_br rf_we retire
    localparam logic [10:0] Z    = 11'h000;
    localparam logic [10:0] IREQ = 11'h400;
    localparam logic [10:0] IRW  = 11'h200;
    localparam logic [10:0] OPW  = 11'h100;
    localparam logic [10:0] ALW  = 11'h080;
    localparam logic [10:0] DLD  = 11'h040;
    localparam logic [10:0] DST  = 11'h060;
    localparam logic [10:0] MDR  = 11'h010;
    localparam logic [10:0] WBN  = 11'h009;
    localparam logic [10:0] WBR  = 11'h00B;
    localparam logic [10:0] WBB  = 11'h00D;

    logic [10:0] strobes;
    assign strobes = {inst_req, ir_we, opnd_we, alu_res_we, data_req,
                      data_wr, mdr_we, pc_we, pc_sel_br, rf_we, retire};

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.INSTRET_W(32)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_rvalid(inst_rvalid),
        .data_req(data_req), .data_wr(data_wr), .data_rvalid(data_rvalid),
        .dec_load(dec_load), .dec_store(dec_store),
        .dec_gr_we(dec_gr_we), .dec_br_taken(dec_br_taken),
        .ir_we(ir_we), .opnd_we(opnd_we), .alu_res_we(alu_res_we),
        .mdr_we(mdr_we), .pc_we(pc_we), .pc_sel_br(pc_sel_br),
        .rf_we(rf_we), .retire(retire), .state(state), .instret(instret)
    );

    task automatic cyc(input logic irv, input logic drv,
                       input logic [2:0] st, input logic [10:0] sb,
                       input string tag);
        inst_rvalid = irv;
        data_rvalid = drv;
        #1;
        checks++;
        assert (state === st) else begin
            failures++;
            $error("FAIL %s state got=%0d exp=%0d", tag, state, st);
        end
        checks++;
        assert (strobes === sb) else begin
            failures++;
            $error("FAIL %s strobes got=%h exp=%h", tag, strobes, sb);
        end
        @(negedge clk);
    endtask

    task automatic chk_instret(input logic [31:0] exp, input string tag);
        checks++;
        assert (instret === exp) else begin
            failures++;
            $error("FAIL %s instret got=%h exp=%h", tag, instret, exp);
        end
    endtask

    task automatic set_dec(input logic ld, input logic st,
                           input logic gwe, input logic br);
        dec_load = ld;
        dec_store = st;
        dec_gr_we = gwe;
        dec_br_taken = br;
    endtask

    initial begin
        reset = 1'b1;
        inst_rvalid = 1'b0;
        data_rvalid = 1'b0;
        set_dec(0, 0, 0, 0);
        @(negedge clk);
        // T1: reset 3 cycles, then add.w
        cyc(1, 1, 3'd0, Z, "rst0");
        cyc(0, 0, 3'd0, Z, "rst1");
        cyc(0, 0, 3'd0, Z, "rst2");
        chk_instret(32'd0, "rst_instret");
        reset = 1'b0;
        set_dec(0, 0, 1, 0);
        cyc(0, 0, 3'd0, IREQ, "t1_ifreq");
        cyc(1, 0, 3'd1, IRW, "t1_ifwait");
        cyc(0, 0, 3'd2, OPW, "t1_id");
        cyc(0, 0, 3'd3, ALW, "t1_exe");
        cyc(0, 0, 3'd6, WBR, "t1_wb");
        chk_instret(32'd1, "t1_instret");
        // T2: ld.w with 4-cycle MEM_WAIT
        set_dec(1, 0, 1, 0);
        cyc(0, 0, 3'd0, IREQ, "t2_ifreq");
        cyc(1, 0, 3'd1, IRW, "t2_ifwait");
        cyc(0, 0, 3'd2, OPW, "t2_id");
        cyc(0, 0, 3'd3, ALW, "t2_exe");
        cyc(0, 0, 3'd4, DLD, "t2_memreq");
        cyc(0, 0, 3'd5, Z, "t2_mw1");
        cyc(0, 0, 3'd5, Z, "t2_mw2");
        cyc(0, 0, 3'd5, Z, "t2_mw3");
        cyc(0, 1, 3'd5, MDR, "t2_mw4");
        cyc(0, 0, 3'd6, WBR, "t2_wb");
        chk_instret(32'd2, "t2_instret");
        // T3: st.w; gr_we asserted to confirm store blocks rf_we
        set_dec(0, 1, 1, 0);
        cyc(0, 0, 3'd0, IREQ, "t3_ifreq");
        cyc(1, 0, 3'd1, IRW, "t3_ifwait");
        cyc(0, 0, 3'd2, OPW, "t3_id");
        cyc(0, 0, 3'd3, ALW, "t3_exe");
        cyc(0, 0, 3'd4, DST, "t3_memreq");
        cyc(0, 1, 3'd5, Z, "t3_mw");
        cyc(0, 0, 3'd6, WBN, "t3_wb");
        chk_instret(32'd3, "t3_instret");
        // T4: beq taken, then bne not taken
        set_dec(0, 0, 0, 1);
        cyc(0, 0, 3'd0, IREQ, "t4a_ifreq");
        cyc(1, 0, 3'd1, IRW, "t4a_ifwait");
        cyc(0, 0, 3'd2, OPW, "t4a_id");
        cyc(0, 0, 3'd3, ALW, "t4a_exe");
        cyc(0, 0, 3'd6, WBB, "t4a_wb");
        set_dec(0, 0, 0, 0);
        cyc(0, 0, 3'd0, IREQ, "t4b_ifreq");
        cyc(1, 0, 3'd1, IRW, "t4b_ifwait");
        cyc(0, 0, 3'd2, OPW, "t4b_id");
        cyc(0, 0, 3'd3, ALW, "t4b_exe");
        cyc(0, 0, 3'd6, WBN, "t4b_wb");
        chk_instret(32'd5, "t4_instret");
        // T5: add.w with spurious rvalids and one IF stall
        set_dec(0, 0, 1, 0);
        cyc(0, 0, 3'd0, IREQ, "t5_ifreq");
        cyc(0, 0, 3'd1, Z, "t5_stall");
        cyc(1, 0, 3'd1, IRW, "t5_ifwait");
        cyc(1, 1, 3'd2, OPW, "t5_id");
        cyc(1, 1, 3'd3, ALW, "t5_exe");
        cyc(1, 1, 3'd6, WBR, "t5_wb");
        chk_instret(32'd6, "t5_instret");
        // T6: reset in MEM_WAIT, then wrap of instret
        set_dec(1, 0, 1, 0);
        cyc(0, 0, 3'd0, IREQ, "t6_ifreq");
        cyc(1, 0, 3'd1, IRW, "t6_ifwait");
        cyc(0, 0, 3'd2, OPW, "t6_id");
        cyc(0, 0, 3'd3, ALW, "t6_exe");
        cyc(0, 0, 3'd4, DLD, "t6_memreq");
        cyc(0, 0, 3'd5, Z, "t6_mw");
        reset = 1'b1;
        cyc(0, 1, 3'd5, Z, "t6_rst_mw");
        cyc(0, 0, 3'd0, Z, "t6_rst_hold");
        chk_instret(32'd0, "t6_rst_instret");
        reset = 1'b0;
        set_dec(0, 0, 1, 0);
        force dut.instret = 32'hFFFF_FFFF;
        #1;
        release dut.instret;
        cyc(0, 0, 3'd0, IREQ, "t6_ifreq2");
        cyc(1, 0, 3'd1, IRW, "t6_ifwait2");
        cyc(0, 0, 3'd2, OPW, "t6_id2");
        cyc(0, 0, 3'd3, ALW, "t6_exe2");
        chk_instret(32'hFFFF_FFFF, "t6_preload");
        cyc(0, 0, 3'd6, WBR, "t6_wb2");
        chk_instret(32'd0, "t6_wrap");
        cyc(0, 0, 3'd0, IREQ, "t6_next");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
